tdm_demux: RTL and testbench

- Receiving end of the team's time-division-multiplexed sample link; the transmit side serialises N channel samples through a select-driven mux.
- This block undoes that: it accepts a serial stream of one sample per beat with a start-of-frame marker, routes each beat to its channel slot through a 1-to-N demux, and publishes a coherent parallel frame.
- Sits between the serial link and per-channel consumers.

---
 rtl/tdm_pkg.sv | 9 +
 rtl/demux_1to_n.sv | 20 ++
 rtl/tdm_demux.sv | 135 +++++++++++++
 tb/tb_tdm_demux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM sample link receive path.
package tdm_pkg;

  typedef enum logic {IDLE, RECV} tdm_state_t;

  localparam int TDM_N_CH = 4;
  localparam int TDM_W    = 8;

endpackage

// File: rtl/demux_1to_n.sv
// 1-to-N select demux: turns a channel index plus enable into a one-hot
// write-enable vector, mirroring the transmit-side sample mux.
module demux_1to_n #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] sel,
  input  logic         en,
  output logic [N-1:0] oh
);

  // Compare against every legal index so an out-of-range sel yields no enable
  always_comb begin
    oh = '0;
    for (int k = 0; k < N; k++) begin
      if (en && (sel == W'(k))) oh[k] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: routes serial beats into channel slots and publishes
// whole frames. Optional err_cnt output under TDM_DEMUX_ERR_CNT_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH,
  parameter int W    = TDM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH-1:0]   ch_strobe,
  output logic [N_CH*W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int            IW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

  tdm_state_t          state;
  logic [IW-1:0]       idx;
  logic [W-1:0]        shadow [N_CH];

  logic                cap_en;
  logic [IW-1:0]       cap_sel;
  logic [N_CH-1:0]     we;
  logic                last_beat;
  logic                abort;
  logic                stray;
  logic [N_CH*W-1:0]   frame_nxt;

  // Stage p0: classify the incoming beat and pick its channel slot
  always_comb begin
    cap_en    = in_valid && (in_sof || (state == RECV));
    cap_sel   = in_sof ? '0 : idx;
    last_beat = in_valid && !in_sof && (state == RECV) && (idx == LAST);
    abort     = in_valid && in_sof && (state == RECV);
    stray     = in_valid && !in_sof && (state == IDLE);
  end

  demux_1to_n #(
    .N (N_CH),
    .W (IW)
  ) u_demux (
    .sel (cap_sel),
    .en  (cap_en),
    .oh  (we)
  );

  // Completed frame = shadow slots with the final beat merged in
  always_comb begin
    frame_nxt = '0;
    for (int k = 0; k < N_CH; k++) begin
      frame_nxt[k*W +: W] = we[k] ? in_data : shadow[k];
    end
  end

  // Stage p1: shadow capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) shadow[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (we[k]) shadow[k] <= in_data;
      end
    end
  end

  // Stage p1: frame FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      ch_strobe <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      out_data  <= '0;
    end else begin
      ch_strobe <= we;
      out_valid <= last_beat;
      frame_err <= abort;
      if (last_beat) out_data <= frame_nxt;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_sof) begin
              idx   <= IW'(1);
              state <= RECV;
            end
          end
          RECV: begin
            if (in_sof) begin
              idx <= IW'(1);
            end else if (idx == LAST) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: begin
            idx   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Aborted frames and stray beats share one saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (abort || stray) begin
      err_cnt <= sat_inc16(err_cnt);
    end
  end
`else
  logic unused_stray;
  assign unused_stray = stray;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8): reset, clean, gapped,
// premature-SOF and back-to-back frames, plus the optional error counter.
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic [3:0]  ch_strobe;
  logic [31:0] out_data;
  logic        out_valid;
  logic        frame_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int fe_cnt = 0;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .ch_strobe (ch_strobe),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic beat(input logic v, input logic sof, input logic [7:0] d);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int ov0, fe0;
  logic [7:0] gb [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    #12;
    chk("rst_stb", ch_strobe, 4'b0000);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_data", out_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // stray non-SOF beat after reset is ignored
    beat(1'b1, 1'b0, 8'h5A);
    chk("stray_stb", ch_strobe, 4'b0000);
    chk("stray_fe", frame_err, 1'b0);

    // reset asserted mid-frame clears outputs immediately
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    chk("mid_stb", ch_strobe, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stb", ch_strobe, 4'b0000);
    chk("arst_data", out_data, 32'h0);
    chk("arst_ov", out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 1'b0, 8'h33);
    chk("post_rst_ign", ch_strobe, 4'b0000);
    beat(1'b1, 1'b0, 8'h44);
    chk("post_rst_ov", out_valid, 1'b0);

    // clean frame
    beat(1'b1, 1'b1, 8'h11);
    chk("cl_stb0", ch_strobe, 4'b0001);
    beat(1'b1, 1'b0, 8'h22);
    chk("cl_stb1", ch_strobe, 4'b0010);
    beat(1'b1, 1'b0, 8'h33);
    chk("cl_stb2", ch_strobe, 4'b0100);
    chk("cl_ov_early", out_valid, 1'b0);
    beat(1'b1, 1'b0, 8'h44);
    chk("cl_stb3", ch_strobe, 4'b1000);
    chk("cl_ov", out_valid, 1'b1);
    chk("cl_data", out_data, 32'h44332211);
    gap(1);
    chk("cl_ov_drop", out_valid, 1'b0);

    // gapped frame, same samples
    ov0 = ov_cnt;
    gb[0] = 8'h11; gb[1] = 8'h22; gb[2] = 8'h33; gb[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, (i == 0), gb[i]);
      gap(2);
    end
    chk("gap_data", out_data, 32'h44332211);
    chk("gap_ov_once", ov_cnt - ov0, 1);

    // premature SOF aborts partial frame
    ov0 = ov_cnt; fe0 = fe_cnt;
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b1, 8'hAA);
    chk("ab_fe", frame_err, 1'b1);
    chk("ab_stb", ch_strobe, 4'b0001);
    beat(1'b1, 1'b0, 8'hBB);
    chk("ab_fe_drop", frame_err, 1'b0);
    chk("ab_data_hold", out_data, 32'h44332211);
    beat(1'b1, 1'b0, 8'hCC);
    beat(1'b1, 1'b0, 8'hDD);
    chk("ab_ov", out_valid, 1'b1);
    chk("ab_data", out_data, 32'hDDCCBBAA);
    gap(1);
    chk("ab_ov_once", ov_cnt - ov0, 1);
    chk("ab_fe_once", fe_cnt - fe0, 1);

    // back-to-back frames
    beat(1'b1, 1'b1, 8'h01);
    beat(1'b1, 1'b0, 8'h02);
    beat(1'b1, 1'b0, 8'h03);
    beat(1'b1, 1'b0, 8'h04);
    chk("b2b_ov1", out_valid, 1'b1);
    chk("b2b_data1", out_data, 32'h04030201);
    beat(1'b1, 1'b1, 8'h05);
    chk("b2b_stb_sof", ch_strobe, 4'b0001);
    chk("b2b_ov_gap", out_valid, 1'b0);
    chk("b2b_fe_none", frame_err, 1'b0);
    beat(1'b1, 1'b0, 8'h06);
    beat(1'b1, 1'b0, 8'h07);
    chk("b2b_data_hold", out_data, 32'h04030201);
    beat(1'b1, 1'b0, 8'h08);
    chk("b2b_ov2", out_valid, 1'b1);
    chk("b2b_data2", out_data, 32'h08070605);
    gap(1);

`ifdef TDM_DEMUX_ERR_CNT_EN
    do_reset();
    chk("ec_rst", err_cnt, 16'd0);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 8'h77);
    chk("ec_stray", err_cnt, 16'd3);
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b1, 8'hAA);
    beat(1'b1, 1'b0, 8'hBB);
    beat(1'b1, 1'b0, 8'hCC);
    beat(1'b1, 1'b0, 8'hDD);
    chk("ec_total", err_cnt, 16'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
